// File: rtl/reset_boot_pkg.sv
// Shared types and constants for the board-level reset/boot sequencer:
// FSM state encoding, synchronizer depths and the soft-reset counter width.
package reset_boot_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int REQ_SYNC_STAGES = 2;
    localparam int RST_SYNC_STAGES = 2;
    localparam int COUNT_W         = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/reset_boot_sequencer_reset_sync.sv
// reset_sync: N-stage reset synchronizer. All stages clear asynchronously when
// rst_n falls; after release a 1 ripples through one stage per clock.
// fill_next tells the consumer that the last stage fills on the coming edge,
// so logic can act on the same edge the synchronized reset releases.
module reset_sync
    import reset_boot_pkg::*;
#(
    parameter int STAGES = RST_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    output logic fill_next,
    output logic rst_n_sync
);

    logic [STAGES-1:0] stage_reg;
    logic [STAGES-1:0] shift_in;

    assign shift_in   = {stage_reg[STAGES-2:0], 1'b1};
    assign fill_next  = stage_reg[STAGES-2];
    assign rst_n_sync = stage_reg[STAGES-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // One synchronizer flop: async clear, shifts toward the output on each edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_reg[gi] <= 1'b0;
            end else begin
                stage_reg[gi] <= shift_in[gi];
            end
        end
    end

endmodule

// File: rtl/reset_boot_sequencer.sv
// reset_boot_sequencer: board reset generator. reset_o asserts asynchronously
// with reset_n, releases synchronously CYCLES clocks after the reset
// synchronizer has filled, and can be re-triggered by a soft-reset button.
// Build option: define RESET_BOOT_DEBOUNCE_EN to require the synchronized
// button level to stay high for DEBOUNCE_CYCLES edges before acceptance.
module reset_boot_sequencer
    import reset_boot_pkg::*;
#(
    parameter int CYCLES          = 20,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sw_reset_req,
    output logic               reset_o,
    output logic               reset_n_o,
    output logic               boot_done,
    output logic [COUNT_W-1:0] reset_count
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    localparam logic [1:0] ST_SYNC = SYNC;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_RUN  = RUN;

    if (CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("reset_boot_sequencer: CYCLES and DEBOUNCE_CYCLES must be >= 1");
    end

    logic                       rst_fill;
    logic                       rst_n_sync;
    logic [REQ_SYNC_STAGES-1:0] req_sync_reg;
    logic                       req_level;
    logic                       armed_reg;
    logic                       accept;
    logic [1:0]                 state_reg, state_next;
    logic [CNT_W-1:0]           hold_cnt_reg, hold_cnt_next;
    logic [COUNT_W-1:0]         count_reg, count_next;
    logic                       reset_o_reg, reset_n_o_reg, boot_done_reg;

    reset_sync #(
        .STAGES (RST_SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (reset_n),
        .fill_next  (rst_fill),
        .rst_n_sync (rst_n_sync)
    );

    assign req_level = req_sync_reg[REQ_SYNC_STAGES-1];

    // Bring the button into the clock domain; arm acceptance one edge after the
    // reset synchronizer releases so a level already high during SYNC is ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sync_reg <= '0;
            armed_reg    <= 1'b0;
        end else begin
            req_sync_reg <= {req_sync_reg[REQ_SYNC_STAGES-2:0], sw_reset_req};
            armed_reg    <= rst_n_sync;
        end
    end

`ifdef RESET_BOOT_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt_reg;
    logic             deb_done_reg;

    // Count consecutive high samples; any low sample restarts the count and
    // re-enables acceptance, so each high period is accepted at most once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_reg  <= '0;
            deb_done_reg <= 1'b0;
        end else if (!armed_reg) begin
            deb_cnt_reg  <= '0;
            deb_done_reg <= req_level;
        end else if (!req_level) begin
            deb_cnt_reg  <= '0;
            deb_done_reg <= 1'b0;
        end else begin
            if (deb_cnt_reg != DEB_W'(DEBOUNCE_CYCLES)) begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
            if (accept) begin
                deb_done_reg <= 1'b1;
            end
        end
    end

    assign accept = armed_reg & req_level & ~deb_done_reg &
                    (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES));
`else
    logic req_prev_reg;

    // Previous synchronized level for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_prev_reg <= 1'b0;
        end else begin
            req_prev_reg <= req_level;
        end
    end

    assign accept = armed_reg & req_level & ~req_prev_reg;
`endif

    // Sequencer: wait for the synchronizer, hold for CYCLES edges, then run;
    // an accepted soft request (re)starts the hold from zero
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        count_next    = count_reg;
        case (state_reg)
            ST_SYNC: begin
                if (rst_fill) begin
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    hold_cnt_next = '0;
                    count_next    = sat_inc(count_reg);
                end else if (hold_cnt_reg == CNT_W'(CYCLES - 1)) begin
                    state_next    = ST_RUN;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                    count_next    = sat_inc(count_reg);
                end
            end
            default: begin
                state_next    = ST_SYNC;
                hold_cnt_next = '0;
            end
        endcase
    end

    // State and registered outputs; reset_n forces reset_o high without a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_SYNC;
            hold_cnt_reg  <= '0;
            count_reg     <= '0;
            reset_o_reg   <= 1'b1;
            reset_n_o_reg <= 1'b0;
            boot_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            count_reg     <= count_next;
            reset_o_reg   <= (state_next != ST_RUN);
            reset_n_o_reg <= (state_next == ST_RUN);
            boot_done_reg <= (state_next == ST_RUN);
        end
    end

    assign reset_o     = reset_o_reg;
    assign reset_n_o   = reset_n_o_reg;
    assign boot_done   = boot_done_reg;
    assign reset_count = count_reg;

endmodule

// File: tb/tb_reset_boot_sequencer.sv
// Self-checking bench for reset_boot_sequencer (CYCLES=20, DEBOUNCE_CYCLES=16).
// Each scenario pushes its expected values into a scoreboard queue as stimulus
// is applied and compares them against the observed values it collects.
`timescale 1ns/1ps
module tb_reset_boot_sequencer;

    localparam int CYCLES  = 20;
    localparam int DEB     = 16;
    localparam int POR_LAT = 2 + CYCLES;
`ifdef RESET_BOOT_DEBOUNCE_EN
    localparam int ACC_LAT = 3 + DEB;
    localparam int PULSE_W = 20;
    localparam int LOW_GAP = 1;
`else
    localparam int ACC_LAT = 3;
    localparam int PULSE_W = 3;
    localparam int LOW_GAP = 7;
`endif

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       reset_o;
    logic       reset_n_o;
    logic       boot_done;
    logic [7:0] reset_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    bit mon_en = 1'b0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] obs_q[$];

    reset_boot_sequencer #(
        .CYCLES          (CYCLES),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_reset_req (sw_reset_req),
        .reset_o      (reset_o),
        .reset_n_o    (reset_n_o),
        .boot_done    (boot_done),
        .reset_count  (reset_count)
    );

    always #5 clk = ~clk;

    // reset_n_o must be the complement of reset_o on every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (reset_n_o !== ~reset_o) begin
                errors++;
                $display("FAIL complement @%0t: reset_n_o=%b reset_o=%b required reset_n_o=%b",
                         $time, reset_n_o, reset_o, ~reset_o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Wait (bounded) for reset_o to reach 'want'; n = edge index or -1.
    // b = first edge where boot_done showed the matching state, or -1.
    task automatic edges_until(input logic want, input int limit, output int n, output int b);
        n = -1;
        b = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (b < 0 && boot_done === !want) b = i;
            if (reset_o === want) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_power_on();
        int n, b;
        logic [31:0] got;
        exp_t e;
        reset_n = 1'b0;
        sw_reset_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sb_q.push_back('{"reset_reset_o", 32'd1});   obs_q.push_back(32'(reset_o));
        sb_q.push_back('{"reset_reset_n_o", 32'd0}); obs_q.push_back(32'(reset_n_o));
        sb_q.push_back('{"reset_boot_done", 32'd0}); obs_q.push_back(32'(boot_done));
        sb_q.push_back('{"reset_count", 32'd0});     obs_q.push_back(32'(reset_count));
        mon_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back('{"por_fall_edge", 32'(POR_LAT)});
        sb_q.push_back('{"por_boot_edge", 32'(POR_LAT)});
        edges_until(1'b0, POR_LAT + 20, n, b);
        obs_q.push_back(32'(n));
        obs_q.push_back(32'(b));
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL power_on_scoreboard: got %0d required an expectation", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", e.tag, got, e.value);
                end
            end
        end
        $display("power_on: reset_o fell on edge %0d, boot_done on edge %0d", n, b);
    endtask

    task automatic test_soft_reset();
        int n, b;
        logic [31:0] got;
        exp_t e;
        @(negedge clk);
        sw_reset_req = 1'b1;
        sb_q.push_back('{"soft_rise_edge", 32'(ACC_LAT)});
        edges_until(1'b1, ACC_LAT + 20, n, b);
        obs_q.push_back(32'(n));
        exp_count++;
        sb_q.push_back('{"soft_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        sb_q.push_back('{"soft_hold_edges", 32'(CYCLES)});
        sb_q.push_back('{"soft_boot_edges", 32'(CYCLES)});
        edges_until(1'b0, CYCLES + 20, n, b);
        obs_q.push_back(32'(n));
        obs_q.push_back(32'(b));
        repeat (100 - ACC_LAT - CYCLES) @(posedge clk);
        #1;
        sb_q.push_back('{"level_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        sb_q.push_back('{"level_reset_o", 32'd0});        obs_q.push_back(32'(reset_o));
        sw_reset_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL soft_scoreboard: got %0d required an expectation", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", e.tag, got, e.value);
                end
            end
        end
        $display("soft_reset: hold %0d edges, reset_count=%0d", n, reset_count);
    endtask

    task automatic test_restart();
        int n, b, low_seen;
        logic [31:0] got;
        exp_t e;
        @(negedge clk);
        sw_reset_req = 1'b1;
        sb_q.push_back('{"restart_first_rise", 32'(ACC_LAT)});
        edges_until(1'b1, ACC_LAT + 20, n, b);
        obs_q.push_back(32'(n));
        exp_count++;
        sw_reset_req = 1'b0;
        repeat (LOW_GAP) @(posedge clk);
        #1;
        sw_reset_req = 1'b1;
        low_seen = 0;
        for (int i = 0; i < ACC_LAT; i++) begin
            @(posedge clk);
            #1;
            if (reset_o !== 1'b1) low_seen++;
        end
        exp_count++;
        sw_reset_req = 1'b0;
        sb_q.push_back('{"restart_low_edges", 32'd0});       obs_q.push_back(32'(low_seen));
        sb_q.push_back('{"restart_count", 32'(exp_count)});  obs_q.push_back(32'(reset_count));
        sb_q.push_back('{"restart_hold_edges", 32'(CYCLES)});
        edges_until(1'b0, CYCLES + 20, n, b);
        obs_q.push_back(32'(n));
        for (int p = 0; p < 300; p++) begin
            sw_reset_req = 1'b1;
            repeat (PULSE_W) @(posedge clk);
            #1;
            sw_reset_req = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        exp_count = (exp_count + 300 > 255) ? 255 : exp_count + 300;
        repeat (CYCLES + 10) @(posedge clk);
        #1;
        sb_q.push_back('{"saturate_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        sb_q.push_back('{"saturate_boot_done", 32'd1});      obs_q.push_back(32'(boot_done));
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL restart_scoreboard: got %0d required an expectation", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", e.tag, got, e.value);
                end
            end
        end
        $display("restart: extended hold %0d edges, reset_count after 300 pulses=%0d", n, reset_count);
    endtask

    task automatic test_async_assert();
        int n, b;
        logic [31:0] got;
        exp_t e;
        sb_q.push_back('{"async_pre_boot_done", 32'd1}); obs_q.push_back(32'(boot_done));
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        exp_count = 0;
        sb_q.push_back('{"async_reset_o", 32'd1});       obs_q.push_back(32'(reset_o));
        sb_q.push_back('{"async_reset_n_o", 32'd0});     obs_q.push_back(32'(reset_n_o));
        sb_q.push_back('{"async_boot_done", 32'd0});     obs_q.push_back(32'(boot_done));
        sb_q.push_back('{"async_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back('{"reboot_fall_edge", 32'(POR_LAT)});
        edges_until(1'b0, POR_LAT + 20, n, b);
        obs_q.push_back(32'(n));
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL async_scoreboard: got %0d required an expectation", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", e.tag, got, e.value);
                end
            end
        end
        $display("async_assert: reset_o asserted without clock, reboot fell on edge %0d", n);
    endtask

    task automatic test_sync_req();
        int n, b;
        logic [31:0] got;
        exp_t e;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sw_reset_req = 1'b1;
        exp_count = 0;
        sb_q.push_back('{"syncreq_fall_edge", 32'(POR_LAT)});
        edges_until(1'b0, POR_LAT + 20, n, b);
        obs_q.push_back(32'(n));
        repeat (10) @(posedge clk);
        #1;
        sb_q.push_back('{"syncreq_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        sb_q.push_back('{"syncreq_reset_o", 32'd0});        obs_q.push_back(32'(reset_o));
        sw_reset_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sw_reset_req = 1'b1;
        sb_q.push_back('{"after_sync_rise", 32'(ACC_LAT)});
        edges_until(1'b1, ACC_LAT + 20, n, b);
        obs_q.push_back(32'(n));
        exp_count++;
        sw_reset_req = 1'b0;
        sb_q.push_back('{"after_sync_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        repeat (CYCLES + 10) @(posedge clk);
        #1;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL syncreq_scoreboard: got %0d required an expectation", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", e.tag, got, e.value);
                end
            end
        end
        $display("sync_req: request during SYNC ignored, reset_count=%0d", reset_count);
    endtask

`ifdef RESET_BOOT_DEBOUNCE_EN
    task automatic test_debounce();
        int n, b;
        logic [31:0] got;
        exp_t e;
        @(negedge clk);
        sw_reset_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sw_reset_req = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        sb_q.push_back('{"deb_short_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        sb_q.push_back('{"deb_short_reset_o", 32'd0});        obs_q.push_back(32'(reset_o));
        @(negedge clk);
        sw_reset_req = 1'b1;
        sb_q.push_back('{"deb_long_rise", 32'(2 + DEB + 1)});
        edges_until(1'b1, 40, n, b);
        obs_q.push_back(32'(n));
        exp_count++;
        repeat (2) @(posedge clk);
        #1;
        sw_reset_req = 1'b0;
        sb_q.push_back('{"deb_long_count", 32'(exp_count)}); obs_q.push_back(32'(reset_count));
        repeat (CYCLES + 10) @(posedge clk);
        #1;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL debounce_scoreboard: got %0d required an expectation", got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", e.tag, got, e.value);
                end
            end
        end
        $display("debounce: long pulse rose on edge %0d, reset_count=%0d", n, reset_count);
    endtask
`endif

    initial begin
        test_power_on();
        test_soft_reset();
        test_restart();
        test_async_assert();
        test_sync_req();
`ifdef RESET_BOOT_DEBOUNCE_EN
        test_debounce();
`endif
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
